// File: rtl/mem_port_scheduler.sv
// Single external memory port shared by NUM_REQ load/store requesters.
// Round-robin grant, one access outstanding, one-cycle load writeback with branch-flush squash.
module mem_port_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DES_W   = 4,
  parameter int BID_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ-1:0]        req_store,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*DES_W-1:0]  req_des,
  input  logic [NUM_REQ*BID_W-1:0]  req_bid,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic                      flush_en,
  input  logic [BID_W-1:0]          flush_id,
  input  logic                      mem_in_done,
  input  logic [DATA_W-1:0]         load_data,
  output logic [ADDR_W-1:0]         out_mem_addr,
  output logic [DATA_W-1:0]         out_mem_data,
  output logic                      out_load_flag,
  output logic                      out_store_flag,
  output logic                      wb_vld,
  output logic [DES_W-1:0]          wb_des,
  output logic [DATA_W-1:0]         wb_data,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WB     = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_nxt;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic [NUM_REQ-1:0] eligible;

  logic               cap_store;
  logic [DES_W-1:0]   cap_des;
  logic [BID_W-1:0]   cap_bid;
  logic               squash;
  logic               flush_hit;
  logic               done_wb;

  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;
  logic [DES_W-1:0]   win_des;
  logic [BID_W-1:0]   win_bid;
  logic               win_store;

  // A requester whose branch is being flushed this cycle must not win the port.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_vld[i] && !(flush_en && (req_bid[i*BID_W +: BID_W] == flush_id));
    end
  end

  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  assign rr_nxt    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign win_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign win_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
  assign win_des   = req_des[int'(grant_idx)*DES_W +: DES_W];
  assign win_bid   = req_bid[int'(grant_idx)*BID_W +: BID_W];
  assign win_store = req_store[grant_idx];

  // A flush landing on the same cycle as completion still kills the writeback.
  assign flush_hit = flush_en && (flush_id == cap_bid);
  assign done_wb   = (state == ACCESS) && mem_in_done && !cap_store && !squash && !flush_hit;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, WB: state_nxt = grant_found ? ACCESS : IDLE;
      ACCESS: begin
        if (mem_in_done) begin
          state_nxt = done_wb ? WB : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr         <= '0;
      squash         <= 1'b0;
      cap_store      <= 1'b0;
      req_ack        <= '0;
      out_mem_addr   <= '0;
      out_mem_data   <= '0;
      out_load_flag  <= 1'b0;
      out_store_flag <= 1'b0;
      wb_vld         <= 1'b0;
      wb_des         <= '0;
      wb_data        <= '0;
      busy           <= 1'b0;
    end else begin
      req_ack <= '0;
      wb_vld  <= 1'b0;
      busy    <= (state_nxt != IDLE);
      if (state != ACCESS) begin
        if (grant_found) begin
          req_ack        <= NUM_REQ'(1) << grant_idx;
          rr_ptr         <= rr_nxt;
          squash         <= 1'b0;
          cap_store      <= win_store;
          out_mem_addr   <= win_addr;
          out_mem_data   <= win_data;
          out_load_flag  <= !win_store;
          out_store_flag <= win_store;
        end
      end else if (mem_in_done) begin
        out_load_flag  <= 1'b0;
        out_store_flag <= 1'b0;
        squash         <= 1'b0;
        if (done_wb) begin
          wb_vld  <= 1'b1;
          wb_des  <= cap_des;
          wb_data <= load_data;
        end
      end else if (flush_hit) begin
        squash <= 1'b1;
      end
    end
  end

  // Tag registers only matter while ACCESS is active, so they carry no reset.
  always_ff @(posedge clk) begin
    if ((state != ACCESS) && grant_found) begin
      cap_des <= win_des;
      cap_bid <= win_bid;
    end
  end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Bench for mem_port_scheduler: vector table of single transactions plus
// hand sequences for round-robin, flush arbitration and mid-access reset.
module tb_mem_port_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vld;
  logic [3:0]  req_store;
  logic [127:0] req_addr;
  logic [127:0] req_data;
  logic [15:0] req_des;
  logic [11:0] req_bid;
  logic [3:0]  req_ack;
  logic        flush_en;
  logic [2:0]  flush_id;
  logic        mem_in_done;
  logic [31:0] load_data;
  logic [31:0] out_mem_addr;
  logic [31:0] out_mem_data;
  logic        out_load_flag;
  logic        out_store_flag;
  logic        wb_vld;
  logic [3:0]  wb_des;
  logic [31:0] wb_data;
  logic        busy;

  mem_port_scheduler #(
    .NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .DES_W(4), .BID_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_store(req_store), .req_addr(req_addr),
    .req_data(req_data), .req_des(req_des), .req_bid(req_bid),
    .req_ack(req_ack), .flush_en(flush_en), .flush_id(flush_id),
    .mem_in_done(mem_in_done), .load_data(load_data),
    .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
    .out_load_flag(out_load_flag), .out_store_flag(out_store_flag),
    .wb_vld(wb_vld), .wb_des(wb_des), .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          store;
    logic [31:0] addr;
    logic [31:0] data;
  } ack_t;

  typedef struct {
    logic [3:0]  des;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    int          idx;
    bit          store;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  des;
    logic [2:0]  bid;
    int          lat;
    logic [31:0] ld;
    bit          fe;
    logic [2:0]  fid;
    int          fat;
    bit          exp_wb;
  } vec_t;

  ack_t exp_ack[$];
  wb_t  exp_wb[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Scoreboard: acks and writebacks are popped in the order they were expected.
  ack_t       mon_a;
  wb_t        mon_w;
  logic [3:0] mon_oh;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("flag_excl", {63'd0, out_load_flag & out_store_flag}, 64'd0);
      if (wb_vld) chk("wb_with_flag", {63'd0, out_load_flag | out_store_flag}, 64'd0);
      if (req_ack != 4'd0) begin
        if (exp_ack.size() == 0) begin
          chk("ack_unexpected", {60'd0, req_ack}, 64'd0);
        end else begin
          mon_a  = exp_ack.pop_front();
          mon_oh = 4'd1 << mon_a.idx;
          chk("ack_idx", {60'd0, req_ack}, {60'd0, mon_oh});
          chk("store_flag", {63'd0, out_store_flag}, {63'd0, mon_a.store});
          chk("load_flag", {63'd0, out_load_flag}, {63'd0, !mon_a.store});
          chk("mem_addr", {32'd0, out_mem_addr}, {32'd0, mon_a.addr});
          chk("mem_data", {32'd0, out_mem_data}, {32'd0, mon_a.data});
        end
      end
      if (wb_vld) begin
        if (exp_wb.size() == 0) begin
          chk("wb_unexpected", {63'd0, wb_vld}, 64'd0);
        end else begin
          mon_w = exp_wb.pop_front();
          chk("wb_des", {60'd0, wb_des}, {60'd0, mon_w.des});
          chk("wb_data", {32'd0, wb_data}, {32'd0, mon_w.data});
        end
      end
    end
  end

  task automatic setreq(input int i, input bit st, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] de, input logic [2:0] b);
    req_store[i]      = st;
    req_addr[i*32 +: 32] = a;
    req_data[i*32 +: 32] = d;
    req_des[i*4 +: 4]    = de;
    req_bid[i*3 +: 3]    = b;
    req_vld[i]        = 1'b1;
  endtask

  task automatic expect_ack(input int i, input bit st, input logic [31:0] a, input logic [31:0] d);
    ack_t e;
    e.idx = i; e.store = st; e.addr = a; e.data = d;
    exp_ack.push_back(e);
  endtask

  task automatic expect_wb(input logic [3:0] de, input logic [31:0] d);
    wb_t e;
    e.des = de; e.data = d;
    exp_wb.push_back(e);
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (req_ack != 4'd0) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      $display("FAIL ack_timeout: got no req_ack within 20 cycles, required one (t=%0t)", $time);
    end
  endtask

  // Called on the first flag-high cycle; completes the access on cycle lat.
  task automatic serve(input int lat, input logic [31:0] ld, input bit fe,
                       input logic [2:0] fid, input int fat);
    for (int c = 1; c <= lat; c++) begin
      chk("flag_held", {63'd0, out_load_flag | out_store_flag}, 64'd1);
      chk("busy_access", {63'd0, busy}, 64'd1);
      if (fe && c == fat) begin
        flush_en = 1'b1;
        flush_id = fid;
      end
      if (c == lat) begin
        mem_in_done = 1'b1;
        load_data   = ld;
      end
      @(negedge clk);
      flush_en    = 1'b0;
      mem_in_done = 1'b0;
    end
    chk("flag_drop", {63'd0, out_load_flag | out_store_flag}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t vecs[7];
  bit   ok;

  initial begin
    vecs[0] = '{0, 1'b0, 32'h40, 32'h0,    4'd5, 3'd0, 3, 32'hDEADBEEF, 1'b0, 3'd0, 0, 1'b1};
    vecs[1] = '{2, 1'b1, 32'h10, 32'h1234, 4'd0, 3'd0, 2, 32'h0,        1'b0, 3'd0, 0, 1'b0};
    vecs[2] = '{1, 1'b0, 32'h80, 32'h0,    4'd7, 3'd3, 4, 32'h11112222, 1'b1, 3'd3, 1, 1'b0};
    vecs[3] = '{3, 1'b0, 32'h84, 32'h0,    4'd9, 3'd3, 3, 32'h33334444, 1'b1, 3'd2, 1, 1'b1};
    vecs[4] = '{0, 1'b0, 32'h88, 32'h0,    4'd2, 3'd5, 2, 32'h55556666, 1'b1, 3'd5, 2, 1'b0};
    vecs[5] = '{1, 1'b1, 32'h8C, 32'hBEEF, 4'd0, 3'd4, 3, 32'h0,        1'b1, 3'd4, 1, 1'b0};
    vecs[6] = '{2, 1'b0, 32'h90, 32'h0,    4'd15, 3'd1, 1, 32'hCAFEF00D, 1'b0, 3'd0, 0, 1'b1};

    rst = 1'b0; req_vld = '0; req_store = '0; req_addr = '0; req_data = '0;
    req_des = '0; req_bid = '0; flush_en = 1'b0; flush_id = '0;
    mem_in_done = 1'b0; load_data = '0;
    #1;
    chk("rst_ack", {60'd0, req_ack}, 64'd0);
    chk("rst_flags", {62'd0, out_load_flag, out_store_flag}, 64'd0);
    chk("rst_wb", {63'd0, wb_vld}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_addr", {32'd0, out_mem_addr}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single transactions from the vector table.
    foreach (vecs[v]) begin
      setreq(vecs[v].idx, vecs[v].store, vecs[v].addr, vecs[v].data, vecs[v].des, vecs[v].bid);
      expect_ack(vecs[v].idx, vecs[v].store, vecs[v].addr, vecs[v].data);
      if (vecs[v].exp_wb) expect_wb(vecs[v].des, vecs[v].ld);
      wait_ack(ok);
      req_vld[vecs[v].idx] = 1'b0;
      if (ok) serve(vecs[v].lat, vecs[v].ld, vecs[v].fe, vecs[v].fid, vecs[v].fat);
      @(negedge clk);
      chk("idle_after", {63'd0, busy}, 64'd0);
    end

    // Round robin with all four requesters held: order 0,1,2,3,0.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) setreq(i, 1'b0, 32'h100 + 32'(i*4), 32'h5500_0000 + 32'(i), 4'(i + 8), 3'd0);
    for (int n = 0; n < 5; n++) begin
      expect_ack(n % 4, 1'b0, 32'h100 + 32'((n % 4)*4), 32'h5500_0000 + 32'(n % 4));
      expect_wb(4'((n % 4) + 8), 32'hA000_0000 + 32'(n));
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_ack(ok);
      if (n == 4) req_vld = '0;
      if (ok) serve(2, 32'hA000_0000 + 32'(n), 1'b0, 3'd0, 0);
    end
    repeat (2) @(negedge clk);

    // Flush in IDLE blocks req0 (bid1); req1 wins, req0 follows after the flush clears.
    do_reset();
    setreq(0, 1'b0, 32'h200, 32'h0, 4'd3, 3'd1);
    setreq(1, 1'b0, 32'h204, 32'h0, 4'd4, 3'd2);
    flush_en = 1'b1; flush_id = 3'd1;
    expect_ack(1, 1'b0, 32'h204, 32'h0);
    expect_wb(4'd4, 32'h0000_0B0B);
    expect_ack(0, 1'b0, 32'h200, 32'h0);
    expect_wb(4'd3, 32'h0000_0A0A);
    @(negedge clk);
    flush_en = 1'b0;
    chk("flush_arb_ack", {60'd0, req_ack}, 64'd2);
    req_vld[1] = 1'b0;
    serve(1, 32'h0000_0B0B, 1'b0, 3'd0, 0);
    wait_ack(ok);
    req_vld[0] = 1'b0;
    if (ok) serve(1, 32'h0000_0A0A, 1'b0, 3'd0, 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of an access; pending requests restart from pointer 0.
    setreq(2, 1'b0, 32'h300, 32'h0, 4'd6, 3'd0);
    expect_ack(2, 1'b0, 32'h300, 32'h0);
    wait_ack(ok);
    req_vld[2] = 1'b0;
    @(negedge clk);
    chk("mid_flag_pre", {63'd0, out_load_flag}, 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_flags", {62'd0, out_load_flag, out_store_flag}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_addr", {32'd0, out_mem_addr}, 64'd0);
    setreq(1, 1'b0, 32'h304, 32'h0, 4'd1, 3'd0);
    setreq(3, 1'b0, 32'h30C, 32'h0, 4'd2, 3'd0);
    expect_ack(1, 1'b0, 32'h304, 32'h0);
    expect_wb(4'd1, 32'h0000_1111);
    expect_ack(3, 1'b0, 32'h30C, 32'h0);
    expect_wb(4'd2, 32'h0000_3333);
    @(negedge clk);
    rst = 1'b1;
    wait_ack(ok);
    req_vld[1] = 1'b0;
    if (ok) serve(1, 32'h0000_1111, 1'b0, 3'd0, 0);
    wait_ack(ok);
    req_vld[3] = 1'b0;
    if (ok) serve(1, 32'h0000_3333, 1'b0, 3'd0, 0);
    repeat (3) @(negedge clk);

    chk("ack_queue_empty", 64'(exp_ack.size()), 64'd0);
    chk("wb_queue_empty", 64'(exp_wb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
